// File: rtl/execute_stage.sv
// Execute stage: condition check, single-cycle ALU, iterative MUL/MOD, EX/MEM register.
module execute_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCSrcE,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic             MemWriteE,
    input  logic             BranchE,
    input  logic             ALUSrcE,
    input  logic             FlagWriteE,
    input  logic [2:0]       ALUControlE,
    input  logic [3:0]       condE,
    input  logic [3:0]       WA3E,
    input  logic [WIDTH-1:0] rd1E,
    input  logic [WIDTH-1:0] rd2E,
    input  logic [WIDTH-1:0] ExtImmE,
    output logic             StallE,
    output logic             PCSrcM,
    output logic             RegWriteM,
    output logic             MemtoRegM,
    output logic             MemWriteM,
    output logic             BranchTakenM,
    output logic [WIDTH-1:0] ALUResultM,
    output logic [WIDTH-1:0] WriteDataM,
    output logic [3:0]       WA3M,
    output logic [3:0]       FlagsQ
);

    localparam int unsigned MSB   = WIDTH - 1;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_MOV = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_MOD = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_d;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] reg_a, reg_b, acc;
    logic             op_mod;

    logic [WIDTH-1:0] src_a, src_b;
    logic             flag_n, flag_z, flag_c, flag_v;
    logic             cond_ex;
    logic             is_iter;
    logic             mod_by_zero;

    logic [WIDTH:0]   add_full, sub_full;
    logic [WIDTH-1:0] alu_result;
    logic             alu_c, alu_v;

    logic [WIDTH:0]   trial, divisor_ext;
    logic [WIDTH-1:0] mul_next, mod_next;

    logic             load, step;
    logic             pcsrc_d, regwrite_d, memtoreg_d, memwrite_d, branch_d;
    logic [WIDTH-1:0] result_d, wdata_d;
    logic [3:0]       wa3_d, flags_d;

    assign src_a = rd1E;
    assign src_b = ALUSrcE ? ExtImmE : rd2E;
    assign {flag_n, flag_z, flag_c, flag_v} = FlagsQ;
    assign is_iter     = (ALUControlE == OP_MUL) || (ALUControlE == OP_MOD);
    assign mod_by_zero = (ALUControlE == OP_MOD) && (src_b == '0);

    // Condition evaluation against the architectural flags
    always_comb begin
        cond_ex = 1'b0;
        case (condE)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = !flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = !flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = !flag_n;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = !flag_z && (flag_n == flag_v);
            4'b1101: cond_ex = flag_z || (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign add_full = {1'b0, src_a} + {1'b0, src_b};
    assign sub_full = {1'b0, src_a} + {1'b0, ~src_b} + (WIDTH+1)'(1);

    // Single-cycle ALU; logic ops and MOV keep C and V
    always_comb begin
        alu_result = '0;
        alu_c      = flag_c;
        alu_v      = flag_v;
        case (ALUControlE)
            OP_ADD: begin
                alu_result = add_full[MSB:0];
                alu_c      = add_full[WIDTH];
                alu_v      = (src_a[MSB] == src_b[MSB]) && (add_full[MSB] != src_a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                alu_result = sub_full[MSB:0];
                alu_c      = sub_full[WIDTH];
                alu_v      = (src_a[MSB] != src_b[MSB]) && (sub_full[MSB] != src_a[MSB]);
            end
            OP_AND:  alu_result = src_a & src_b;
            OP_ORR:  alu_result = src_a | src_b;
            OP_MOV:  alu_result = src_b;
            default: alu_result = '0;
        endcase
    end

    // One shift-add or restoring-division step on the latched operands
    assign trial       = {acc, reg_a[MSB]};
    assign divisor_ext = {1'b0, reg_b};
    assign mod_next    = (trial >= divisor_ext) ? WIDTH'(trial - divisor_ext) : WIDTH'(trial);
    assign mul_next    = reg_b[0] ? acc + reg_a : acc;

    // Next-state, stall and next EX/MEM register contents
    always_comb begin
        state_d    = state;
        StallE     = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        pcsrc_d    = PCSrcE & cond_ex;
        regwrite_d = RegWriteE & cond_ex & (ALUControlE != OP_CMP);
        memtoreg_d = MemtoRegE;
        memwrite_d = MemWriteE & cond_ex;
        branch_d   = BranchE & cond_ex;
        result_d   = alu_result;
        wdata_d    = rd2E;
        wa3_d      = WA3E;
        flags_d    = FlagsQ;
        if (FlagWriteE && cond_ex) begin
            flags_d = {alu_result[MSB], (alu_result == '0), alu_c, alu_v};
        end
        case (state)
            IDLE: begin
                if (is_iter && cond_ex) begin
                    StallE  = 1'b1;
                    load    = 1'b1;
                    state_d = mod_by_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                StallE = 1'b1;
                step   = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                result_d = acc;
                flags_d  = FlagsQ;
                if (FlagWriteE && cond_ex) begin
                    flags_d = {acc[MSB], (acc == '0), flag_c, flag_v};
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (StallE) begin
            pcsrc_d    = 1'b0;
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            memwrite_d = 1'b0;
            branch_d   = 1'b0;
            result_d   = '0;
            wdata_d    = '0;
            wa3_d      = '0;
            flags_d    = FlagsQ;
        end
        if (rst) begin
            StallE = 1'b0;
        end
    end

    // State register
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Iterative MUL/MOD datapath
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            reg_a  <= '0;
            reg_b  <= '0;
            acc    <= '0;
            op_mod <= 1'b0;
        end else if (load) begin
            cnt    <= '0;
            reg_a  <= src_a;
            reg_b  <= src_b;
            acc    <= mod_by_zero ? src_a : '0;
            op_mod <= (ALUControlE == OP_MOD);
        end else if (step) begin
            cnt   <= cnt + CNT_W'(1);
            reg_a <= reg_a << 1;
            if (op_mod) begin
                acc <= mod_next;
            end else begin
                acc   <= mul_next;
                reg_b <= reg_b >> 1;
            end
        end
    end

    // EX/MEM register and flags
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            PCSrcM       <= 1'b0;
            RegWriteM    <= 1'b0;
            MemtoRegM    <= 1'b0;
            MemWriteM    <= 1'b0;
            BranchTakenM <= 1'b0;
            ALUResultM   <= '0;
            WriteDataM   <= '0;
            WA3M         <= '0;
            FlagsQ       <= '0;
        end else begin
            PCSrcM       <= pcsrc_d;
            RegWriteM    <= regwrite_d;
            MemtoRegM    <= memtoreg_d;
            MemWriteM    <= memwrite_d;
            BranchTakenM <= branch_d;
            ALUResultM   <= result_d;
            WriteDataM   <= wdata_d;
            WA3M         <= wa3_d;
            FlagsQ       <= flags_d;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage with hand-computed expectations.
module tb_execute_stage;

    logic        clk;
    logic        rst;
    logic        PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, FlagWriteE;
    logic [2:0]  ALUControlE;
    logic [3:0]  condE, WA3E;
    logic [31:0] rd1E, rd2E, ExtImmE;
    logic        StallE, PCSrcM, RegWriteM, MemtoRegM, MemWriteM, BranchTakenM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [3:0]  WA3M, FlagsQ;

    int checks = 0;
    int errors = 0;

    execute_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .MemWriteE(MemWriteE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
        .FlagWriteE(FlagWriteE), .ALUControlE(ALUControlE), .condE(condE),
        .WA3E(WA3E), .rd1E(rd1E), .rd2E(rd2E), .ExtImmE(ExtImmE),
        .StallE(StallE), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM),
        .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .BranchTakenM(BranchTakenM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M), .FlagsQ(FlagsQ)
    );

    // Clock: starts high, falling (active) edges at 5, 15, 25, ...
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with its expected value
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance past one active edge, sample well before the next one
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] cond,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic alusrc, input logic fw, input logic rw);
        ALUControlE = op;
        condE       = cond;
        rd1E        = a;
        rd2E        = b;
        ExtImmE     = imm;
        ALUSrcE     = alusrc;
        FlagWriteE  = fw;
        RegWriteE   = rw;
        BranchE     = 1'b0;
        PCSrcE      = 1'b0;
        MemWriteE   = 1'b0;
        MemtoRegE   = 1'b0;
        WA3E        = 4'd1;
    endtask

    // Run an issued MUL/MOD to completion; returns stall cycles and bubble violations
    task automatic run_iter(output int stalls, output int bad_bubbles);
        stalls      = 0;
        bad_bubbles = 0;
        #1;
        while (StallE && stalls < 40) begin
            stalls++;
            tick();
            if (stalls == 1) rd1E = ~rd1E;
            if (RegWriteM !== 1'b0 || ALUResultM !== 32'd0 || WA3M !== 4'd0) bad_bubbles++;
        end
        tick();
    endtask

    localparam logic [2:0] ADD = 3'b000, ORR = 3'b011, MUL = 3'b101, MOD = 3'b110, CMP = 3'b111;
    localparam logic [3:0] EQ = 4'b0000, NE = 4'b0001, AL = 4'b1110;

    // Condition table evaluated with flags NZCV=0010
    logic [3:0] cond_tab [13];
    logic       cond_exp [13];

    initial begin
        int stalls, bad;
        cond_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
                     4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
        cond_exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                     1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        issue(ADD, EQ, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check("rst_result", ALUResultM, 32'd0);
        check("rst_flags", 32'(FlagsQ), 32'd0);
        check("rst_stall", 32'(StallE), 32'd0);
        rst = 1'b0;

        // ADD overflow sets N and V
        issue(ADD, AL, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 1'b1);
        WA3E = 4'd3;
        #1;
        check("add_stall", 32'(StallE), 32'd0);
        tick();
        check("add_result", ALUResultM, 32'h8000_0000);
        check("add_flags", 32'(FlagsQ), 32'b1001);
        check("add_regwrite", 32'(RegWriteM), 32'd1);
        check("add_wa3", 32'(WA3M), 32'd3);
        check("add_wdata", WriteDataM, 32'd1);

        // CMP equal operands: Z=1, C=1, no register write
        issue(CMP, AL, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 1'b1);
        tick();
        check("cmp_flags", 32'(FlagsQ), 32'b0110);
        check("cmp_regwrite", 32'(RegWriteM), 32'd0);

        // EQ branch taken with Z=1, immediate operand
        issue(ADD, EQ, 32'h100, 32'd0, 32'h20, 1'b1, 1'b0, 1'b0);
        BranchE = 1'b1;
        PCSrcE  = 1'b1;
        tick();
        check("eq_branch", 32'(BranchTakenM), 32'd1);
        check("eq_pcsrc", 32'(PCSrcM), 32'd1);
        check("eq_result", ALUResultM, 32'h120);

        // NE instruction squashed with Z=1
        issue(ADD, NE, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1'b1);
        MemWriteE = 1'b1;
        tick();
        check("ne_regwrite", 32'(RegWriteM), 32'd0);
        check("ne_memwrite", 32'(MemWriteM), 32'd0);
        check("ne_flags", 32'(FlagsQ), 32'b0110);

        // ORR updates N,Z and keeps C,V
        issue(ORR, AL, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b1, 1'b1);
        tick();
        check("orr_result", ALUResultM, 32'h8000_0001);
        check("orr_flags", 32'(FlagsQ), 32'b1010);

        // MUL 0x00010001 * 0x0000FFFF
        issue(MUL, AL, 32'h0001_0001, 32'h0000_FFFF, 32'd0, 1'b0, 1'b0, 1'b1);
        WA3E = 4'd5;
        run_iter(stalls, bad);
        check("mul_stalls", 32'(stalls), 32'd33);
        check("mul_bubbles", 32'(bad), 32'd0);
        check("mul_result", ALUResultM, 32'hFFFF_FFFF);
        check("mul_regwrite", 32'(RegWriteM), 32'd1);
        check("mul_wa3", 32'(WA3M), 32'd5);
        check("mul_flags", 32'(FlagsQ), 32'b1010);

        // Modulo 1000 % 7 via immediate
        issue(MOD, AL, 32'd1000, 32'd0, 32'd7, 1'b1, 1'b1, 1'b1);
        run_iter(stalls, bad);
        check("mod_stalls", 32'(stalls), 32'd33);
        check("mod_bubbles", 32'(bad), 32'd0);
        check("mod_result", ALUResultM, 32'd6);
        check("mod_flags", 32'(FlagsQ), 32'b0010);

        // Modulo by zero returns the dividend after a single stall cycle
        issue(MOD, AL, 32'd1000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        run_iter(stalls, bad);
        check("mod0_stalls", 32'(stalls), 32'd1);
        check("mod0_result", ALUResultM, 32'd1000);
        check("mod0_regwrite", 32'(RegWriteM), 32'd1);

        // MUL with a failing condition: no stall, gated controls low
        issue(MUL, EQ, 32'd3, 32'd5, 32'd0, 1'b0, 1'b1, 1'b1);
        #1;
        check("nmul_stall", 32'(StallE), 32'd0);
        tick();
        check("nmul_regwrite", 32'(RegWriteM), 32'd0);
        check("nmul_flags", 32'(FlagsQ), 32'b0010);

        // Condition codes with NZCV=0010, observed on BranchTakenM
        for (int i = 0; i < 13; i++) begin
            issue(ADD, cond_tab[i], 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
            BranchE = 1'b1;
            tick();
            check($sformatf("cond_%b", cond_tab[i]), 32'(BranchTakenM), 32'(cond_exp[i]));
        end

        // Reset in the middle of a MUL (counter at 10)
        issue(MUL, AL, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) tick();
        check("midmul_stall", 32'(StallE), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_stall", 32'(StallE), 32'd0);
        check("midrst_flags", 32'(FlagsQ), 32'd0);
        check("midrst_result", ALUResultM, 32'd0);
        check("midrst_regwrite", 32'(RegWriteM), 32'd0);
        #1;
        rst = 1'b0;
        issue(ADD, AL, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 1'b1);
        #1;
        check("post_stall", 32'(StallE), 32'd0);
        tick();
        check("post_result", ALUResultM, 32'd7);
        check("post_regwrite", 32'(RegWriteM), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (EX) stage of the RSA pipeline CPU. Sits directly downstream of the ID/EX pipeline register and consumes its E-stage outputs.
- Evaluates the condition code against an internal NZCV flag register, selects the ALU operand, and executes single-cycle ALU operations.
- Runs iterative 32-bit MUL and MOD operations for RSA modular arithmetic, stalling the pipeline while they run.
- Registers the results into the EX/MEM boundary (M-stage outputs).

Parameters:
- WIDTH, 32, datapath width; MUL/MOD iteration count equals WIDTH.

Ports:
- clk  in  1  pipeline clock; all state updates on the falling edge.
- rst  in  1  asynchronous, active-high reset.
- PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, FlagWriteE  in  1 each  E-stage controls.
- ALUControlE  in  3  operation: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MOV, 101 MUL, 110 MOD, 111 CMP.
- condE  in  4  condition field.
- WA3E  in  4  destination register.
- rd1E, rd2E, ExtImmE  in  WIDTH each  operands.
- StallE  out  1  combinational; upstream holds ID/EX and IF/ID while high.
- PCSrcM, RegWriteM, MemtoRegM, MemWriteM, BranchTakenM  out  1 each  registered, condition-gated controls.
- ALUResultM, WriteDataM  out  WIDTH each  registered result and store data (rd2E).
- WA3M  out  4  registered destination register.
- FlagsQ  out  4  architectural flags, {N,Z,C,V}.

Behaviour:
- SrcB = ALUSrcE ? ExtImmE : rd2E. SrcA = rd1E.
- CondEx is combinational from FlagsQ:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N.
  - 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1.
  - All other codes: 0.
- Gated controls: PCSrc, RegWrite, MemWrite and Branch are each ANDed with CondEx. RegWrite is additionally forced to 0 for CMP.
- Single-cycle ops, arithmetic:
  - ADD: SrcA+SrcB; C = carry out; V = signed overflow.
  - SUB/CMP: SrcA+~SrcB+1; C = 1 means no borrow.
  - Results are WIDTH bits; carry out is discarded from the result.
- Single-cycle ops, logic and MOV: AND, ORR and MOV (=SrcB) set N and Z only; C and V are preserved.
- Flags update:
  - Occurs on the edge at which the M register captures the instruction, only if FlagWriteE & CondEx.
  - N = result MSB; Z = (result==0).
  - MUL and MOD update N and Z only.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If (ALUControlE is MUL or MOD) & CondEx: StallE=1, the M register loads a bubble (all controls 0, data 0), the iteration counter clears, and the state goes to BUSY.
  - Exception: MOD with SrcB==0 goes straight to DONE.
  - Otherwise StallE=0 and the M register captures normally.
- BUSY:
  - StallE=1 and the M register loads a bubble.
  - One iteration per edge: MUL is shift-add producing the low WIDTH bits of the product; MOD is restoring division keeping the remainder.
  - When the counter reaches WIDTH-1, the state goes to DONE.
- DONE:
  - StallE=0; the M register captures the iterative result with the gated controls; flags update per the rules above; the state returns to IDLE.
- Latency:
  - MUL/MOD: StallE is high for exactly WIDTH+1 cycles (33); the result appears in ALUResultM after the 34th falling edge.
  - MOD by 0: StallE is high for 1 cycle; the result is SrcA.
- MUL/MOD with CondEx=0: no stall; treated as a single-cycle no-op with all gated controls 0.
- Operands are latched internally at the IDLE->BUSY transition. Input changes during BUSY are ignored.
- Reset:
  - Reset asserted at any time (including mid-BUSY) immediately forces all M outputs to 0, FlagsQ=0000, state IDLE, counter 0.
  - StallE=0 while in reset.
- DONE never restarts an operation, even though ID/EX still holds the same MUL/MOD in that cycle.

Test Plan:
- Reset mid-MUL (BUSY, counter=10): assert rst -> StallE=0 and every M output is 0 immediately; after release, an ADD 3+4 gives ALUResultM=7.
- ADD with FlagWriteE=1, rd1=0x7FFFFFFF, rd2=1 -> ALUResultM=0x80000000, FlagsQ=1001 (N=1, Z=0, C=0, V=1). Then CMP 5,5 -> FlagsQ=0110 (Z=1, C=1), RegWriteM=0.
- With Z=1: an EQ branch gives BranchTakenM=1, PCSrcM=1; an NE ADD with RegWriteE=1 gives RegWriteM=0 and FlagsQ unchanged.
- MUL rd1=0x00010001, rd2=0x0000FFFF -> StallE high for 33 cycles with bubbles in M; then ALUResultM=0xFFFFFFFF and RegWriteM=1.
- MOD rd1=1000, ExtImm=7 with ALUSrcE=1 -> 33-cycle stall, ALUResultM=6. MOD rd1=1000, rd2=0 -> 1-cycle stall, ALUResultM=1000.
